// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the uart_tx_arbiter slice: FSM encoding, state width,
// default requester count and a small index helper.
package uart_tx_arbiter_pkg;

    localparam int STATE_W      = 2;
    localparam int NREQ_DEFAULT = 4;

    localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] ST_START     = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [STATE_W-1:0] ST_WAIT_DONE = 2'd3;

    // Index width that stays at least one bit wide for any legal requester count.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. It returns the first set request
// found when searching from pointer upward, modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    int k;

    // Scan from farthest to nearest so the candidate closest to pointer wins.
    always_comb begin
        k     = 0;
        index = '0;
        any   = |req;
        for (int off = N - 1; off >= 0; off--) begin
            k = (int'(pointer) + off) % N;
            if (req[k]) begin
                index = IW'(k);
            end
        end
        grant = any ? (N'(1) << index) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter among NREQ byte
// producers. Optional grant locking for multi-byte messages: UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*DW-1:0] i_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [NREQ-1:0]    i_last,
`endif
    output logic [NREQ-1:0]    o_ack,
    output logic [NREQ-1:0]    o_grant,
    output logic               o_tx_start,
    output logic [DW-1:0]      o_tx_data,
    input  logic               i_tx_ready,
    output logic               o_busy
);

    localparam int IW = idx_w(NREQ);

    logic [STATE_W-1:0] state_reg;
    logic [IW-1:0]      ptr_reg;
    logic [IW-1:0]      idx_reg;
    logic [NREQ-1:0]    grant_reg;
    logic [NREQ-1:0]    ack_reg;
    logic               start_reg;
    logic [DW-1:0]      data_reg;

    logic [DW-1:0]      data_arr [NREQ];
    logic [NREQ-1:0]    elig_req;
    logic [NREQ-1:0]    pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = i_data[gi*DW +: DW];
        end
    endgenerate

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    endfunction

`ifdef UART_ARB_LOCK_EN
    logic lock_reg;
    // While locked the pointer holds the owner, so masking to it restricts eligibility.
    assign elig_req = lock_reg ? (i_req & (NREQ'(1) << ptr_reg)) : i_req;
`else
    assign elig_req = i_req;
`endif

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req     (elig_req),
        .pointer (ptr_reg),
        .grant   (pick_grant),
        .index   (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            grant_reg <= '0;
            ack_reg   <= '0;
            start_reg <= 1'b0;
            data_reg  <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_reg  <= 1'b0;
`endif
        end else begin
            ack_reg   <= '0;
            start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
`ifdef UART_ARB_LOCK_EN
                    if (lock_reg && !i_req[ptr_reg]) begin
                        lock_reg <= 1'b0;
                        ptr_reg  <= next_idx(ptr_reg);
                    end else
`endif
                    if (pick_any && i_tx_ready) begin
                        data_reg  <= data_arr[pick_idx];
                        grant_reg <= pick_grant;
                        ack_reg   <= pick_grant;
                        idx_reg   <= pick_idx;
`ifdef UART_ARB_LOCK_EN
                        lock_reg  <= !i_last[pick_idx];
`endif
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    // Registered so the start pulse trails the ack by one cycle.
                    start_reg <= 1'b1;
                    state_reg <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!i_tx_ready) begin
                        state_reg <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_tx_ready) begin
                        grant_reg <= '0;
`ifdef UART_ARB_LOCK_EN
                        ptr_reg   <= lock_reg ? idx_reg : next_idx(idx_reg);
`else
                        ptr_reg   <= next_idx(idx_reg);
`endif
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_ack      = ack_reg;
    assign o_grant    = grant_reg;
    assign o_tx_start = start_reg;
    assign o_tx_data  = data_reg;
    assign o_busy     = (state_reg != ST_IDLE);

endmodule
